// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared MIPS core definitions: PcSrc codes, fetch FSM states
//                and the default reset PC.
//  Revision    : 1.0  initial release
// ============================================================================
package mips_pkg;

    // Next-PC select codes driven by the controller
    localparam logic [1:0] PC_SEQ = 2'd0;
    localparam logic [1:0] PC_BEQ = 2'd1;
    localparam logic [1:0] PC_J   = 2'd2;
    localparam logic [1:0] PC_JR  = 2'd3;

    // Default boot address (word aligned)
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    // Instruction fetch FSM states
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_ERR   = 2'd2
    } fetch_state_t;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/ifu_npc.sv
`default_nettype none
// ============================================================================
//  Module      : npc
//  Description : Combinational next-PC generator (seq / beq / j / jr) and
//                pc+8 link value for jal.
//  Revision    : 1.0  initial release
// ============================================================================
module npc
    import mips_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic [1:0]  pc_src,
    input  logic        zero,
    input  logic [31:0] rs_data,
    output logic [31:0] npc,
    output logic [31:0] pc8
);

    logic [31:0] w_pc4;
    logic [31:0] w_br_off;
    logic        unused_opcode;

    assign w_pc4    = pc + 32'd4;
    assign pc8      = pc + 32'd8;
    // Sign-extended word offset of the branch immediate
    assign w_br_off = {{14{instr[15]}}, instr[15:0], 2'b00};

    // Opcode field is decoded by the controller, not here
    assign unused_opcode = &{1'b0, instr[31:26]};

    // Select the next PC from the controller's PcSrc code
    always_comb begin
        npc = w_pc4;
        case (pc_src)
            PC_SEQ:  npc = w_pc4;
            PC_BEQ:  npc = zero ? (w_pc4 + w_br_off) : w_pc4;
            PC_J:    npc = {w_pc4[31:28], instr[25:0], 2'b00};
            PC_JR:   npc = rs_data;
            default: npc = w_pc4;
        endcase
    end

endmodule : npc
`default_nettype wire

// File: rtl/ifu.sv
`default_nettype none
// ============================================================================
//  Module      : ifu
//  Description : Instruction fetch unit. Holds the PC, fetches one word over
//                a req/ack handshake, presents it to decode and advances the
//                PC on commit. Misaligned targets trap into a sticky error.
//  Revision    : 1.0  initial release
// ============================================================================
module ifu
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  pc_src,
    input  logic        zero,
    input  logic [31:0] rs_data,
    input  logic        commit,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc8,
    output logic        fetch_err,
    output logic [31:0] retired
);

    fetch_state_t r_state;
    logic [31:0]  w_npc;

    npc u_npc (
        .pc      (pc),
        .instr   (instr),
        .pc_src  (pc_src),
        .zero    (zero),
        .rs_data (rs_data),
        .npc     (w_npc),
        .pc8     (pc8)
    );

    // Fetch address is the PC itself; stable for the whole FETCH phase
    assign imem_addr = pc;

    // Fetch FSM with registered handshake/status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_FETCH;
            pc          <= RESET_PC;
            instr       <= 32'd0;
            retired     <= 32'd0;
            imem_req    <= 1'b1;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        r_state     <= ST_HOLD;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (commit) begin
                        retired     <= retired + 32'd1;
                        instr_valid <= 1'b0;
                        if (w_npc[1:0] == 2'b00) begin
                            pc       <= w_npc;
                            r_state  <= ST_FETCH;
                            imem_req <= 1'b1;
                        end else begin
                            r_state   <= ST_ERR;
                            fetch_err <= 1'b1;
                        end
                    end
                end
                ST_ERR: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                    fetch_err   <= 1'b1;
                end
                default: begin
                    r_state     <= ST_ERR;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                    fetch_err   <= 1'b1;
                end
            endcase
        end
    end

endmodule : ifu
`default_nettype wire

// File: tb/tb_ifu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ifu
//  Description : Scoreboard testbench for ifu. Each issued fetch pushes the
//                expected {pc, instr, pc8}; a monitor pops and compares when
//                instr_valid rises. Directed checks cover commit/PC updates,
//                error trap, reset and handshake stability.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ifu;

    logic        clk;
    logic        reset;
    logic [1:0]  pc_src;
    logic        zero;
    logic [31:0] rs_data;
    logic        commit;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc8;
    logic        fetch_err;
    logic [31:0] retired;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc8;
    } exp_t;

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_ret;
    logic        prev_valid = 1'b0;

    ifu dut (
        .clk         (clk),
        .reset       (reset),
        .pc_src      (pc_src),
        .zero        (zero),
        .rs_data     (rs_data),
        .commit      (commit),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc8         (pc8),
        .fetch_err   (fetch_err),
        .retired     (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare the presented instruction against the scoreboard
    always @(negedge clk) begin
        if (instr_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_pc", pc, e.pc);
                chk("sb_instr", instr, e.instr);
                chk("sb_pc8", pc8, e.pc8);
            end
        end
        prev_valid = instr_valid;
    end

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset   = 1'b0;
        exp_pc  = 32'h0000_3000;
        exp_ret = 32'd0;
        chk("rst_pc", pc, 32'h0000_3000);
        chk("rst_req", {31'd0, imem_req}, 32'd1);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_err", {31'd0, fetch_err}, 32'd0);
        chk("rst_retired", retired, 32'd0);
        chk("rst_instr", instr, 32'd0);
    endtask

    // Fetch with 'delay' idle cycles before ack; optional stray commit pulse
    task automatic fetch(input logic [31:0] word, input int delay, input int commit_at);
        exp_t e;
        for (int i = 0; i < delay; i++) begin
            imem_ack = 1'b0;
            if (i == commit_at) begin
                commit  = 1'b1;
                pc_src  = 2'd3;
                rs_data = 32'h0000_3102;
            end
            step();
            commit = 1'b0;
            chk("wait_req", {31'd0, imem_req}, 32'd1);
            chk("wait_addr", imem_addr, exp_pc);
            chk("wait_valid", {31'd0, instr_valid}, 32'd0);
        end
        if (commit_at >= 0) begin
            chk("fetch_commit_pc", pc, exp_pc);
            chk("fetch_commit_ret", retired, exp_ret);
        end
        e.pc    = exp_pc;
        e.instr = word;
        e.pc8   = exp_pc + 32'd8;
        exp_q.push_back(e);
        imem_ack   = 1'b1;
        imem_rdata = word;
        step();
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        chk("hold_valid", {31'd0, instr_valid}, 32'd1);
        chk("hold_req", {31'd0, imem_req}, 32'd0);
    endtask

    // Commit the held instruction; exp_npc is the hand-computed target
    task automatic do_commit(input logic [1:0] src, input logic z,
                             input logic [31:0] rs, input logic [31:0] exp_npc);
        commit  = 1'b1;
        pc_src  = src;
        zero    = z;
        rs_data = rs;
        step();
        commit  = 1'b0;
        exp_ret = exp_ret + 32'd1;
        chk("cm_retired", retired, exp_ret);
        chk("cm_valid", {31'd0, instr_valid}, 32'd0);
        if (exp_npc[1:0] == 2'b00) begin
            exp_pc = exp_npc;
            chk("cm_pc", pc, exp_pc);
            chk("cm_addr", imem_addr, exp_pc);
            chk("cm_req", {31'd0, imem_req}, 32'd1);
            chk("cm_err", {31'd0, fetch_err}, 32'd0);
        end else begin
            chk("err_pc", pc, exp_pc);
            chk("err_flag", {31'd0, fetch_err}, 32'd1);
            chk("err_req", {31'd0, imem_req}, 32'd0);
        end
    endtask

    initial begin
        reset      = 1'b1;
        pc_src     = 2'd0;
        zero       = 1'b0;
        rs_data    = 32'd0;
        commit     = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        exp_pc     = 32'h0000_3000;
        exp_ret    = 32'd0;

        do_reset();

        // First fetch acked immediately, then sequential commit
        fetch(32'h3421_0005, 0, -1);
        chk("hold_pc8", pc8, 32'h0000_3008);
        // Ack while not requesting must not disturb instr
        imem_ack   = 1'b1;
        imem_rdata = 32'h1111_2222;
        step();
        imem_ack   = 1'b0;
        chk("ack_ignored_instr", instr, 32'h3421_0005);
        do_commit(2'd0, 1'b0, 32'd0, 32'h0000_3004);

        // Slow fetch with a stray commit during FETCH, then jr to 0x3010
        fetch(32'h0000_0000, 5, 2);
        do_commit(2'd3, 1'b0, 32'h0000_3010, 32'h0000_3010);

        // beq taken (offset -1 word) back onto itself
        fetch(32'h1000_FFFF, 0, -1);
        do_commit(2'd1, 1'b1, 32'd0, 32'h0000_3010);
        // beq not taken
        fetch(32'h1000_FFFF, 1, -1);
        do_commit(2'd1, 1'b0, 32'd0, 32'h0000_3014);

        // jr to 0x3020, then jal
        fetch(32'h0000_0000, 0, -1);
        do_commit(2'd3, 1'b0, 32'h0000_3020, 32'h0000_3020);
        fetch(32'h0C00_0C10, 0, -1);
        chk("jal_pc8", pc8, 32'h0000_3028);
        do_commit(2'd2, 1'b0, 32'd0, 32'h0000_3040);

        // Misaligned jr traps into ERR
        fetch(32'h0000_0008, 0, -1);
        do_commit(2'd3, 1'b0, 32'h0000_3102, 32'h0000_3102);
        imem_ack = 1'b1;
        commit   = 1'b1;
        step();
        step();
        step();
        imem_ack = 1'b0;
        commit   = 1'b0;
        chk("err_sticky", {31'd0, fetch_err}, 32'd1);
        chk("err_hold_pc", pc, 32'h0000_3040);
        chk("err_hold_ret", retired, exp_ret);
        chk("err_hold_valid", {31'd0, instr_valid}, 32'd0);
        chk("err_hold_req", {31'd0, imem_req}, 32'd0);

        // Reset clears the error
        do_reset();

        // PC wrap at top of address space
        fetch(32'h0000_0000, 0, -1);
        do_commit(2'd3, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
        fetch(32'h0000_0000, 0, -1);
        do_commit(2'd0, 1'b0, 32'd0, 32'h0000_0000);

        // Reset during FETCH with an ack in the reset cycle
        reset      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hCAFE_F00D;
        step();
        reset      = 1'b0;
        imem_ack   = 1'b0;
        chk("rstf_pc", pc, 32'h0000_3000);
        chk("rstf_instr", instr, 32'd0);
        chk("rstf_valid", {31'd0, instr_valid}, 32'd0);
        chk("rstf_req", {31'd0, imem_req}, 32'd1);
        chk("rstf_retired", retired, 32'd0);
        step();
        chk("rstf_still_fetch", {31'd0, instr_valid}, 32'd0);

        step();
        chk("sb_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule : tb_ifu
`default_nettype wire

// File: doc/ifu.md
# ifu

Instruction fetch unit for the MIPS core. It holds the program counter, fetches one instruction at a time from instruction memory over a request/acknowledge handshake, and presents that instruction to the decode/controller stage. On each commit it computes the next PC from the controller's PcSrc code (0 pc+4, 1 beq, 2 j/jal, 3 jr), the ALU zero flag and the rs register value. It also supplies PC+8 for the jal link write-back path.

## Interface
- RESET_PC, 32'h0000_3000, PC value loaded on reset; must be word-aligned.
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- pc_src  in  2  next-PC select from controller: 0 pc+4, 1 beq, 2 j/jal, 3 jr
- zero  in  1  ALU equality flag; qualifies beq
- rs_data  in  32  GPR[rs]; jr target
- commit  in  1  core has finished the current instruction; sampled only in HOLD
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address (= pc)
- imem_ack  in  1  rdata valid this cycle; only meaningful while imem_req=1
- imem_rdata  in  32  instruction word
- instr  out  32  latched instruction
- instr_valid  out  1  instr/pc are valid for the core
- pc  out  32  address of instr
- pc8  out  32  pc+8, jal link value
- fetch_err  out  1  sticky misaligned-target error
- retired  out  32  committed-instruction counter

## Operation
- FSM states: FETCH, HOLD, ERR.
- FETCH:
  - imem_req=1; imem_addr=pc, held stable until ack.
  - instr_valid=0.
  - On imem_ack: instr<=imem_rdata, go to HOLD.
  - commit is ignored in this state.
- HOLD:
  - imem_req=0; instr_valid=1.
  - On commit: compute npc, then retired<=retired+1 (wraps mod 2^32).
  - If npc[1:0]==0: pc<=npc, go to FETCH.
  - Otherwise: pc unchanged, go to ERR.
- ERR:
  - imem_req=0, instr_valid=0, fetch_err=1.
  - Held until reset; all inputs are ignored.
- Next-PC computation (all arithmetic 32-bit, wraps mod 2^32), with pc4=pc+4:
  - pc_src=0: npc=pc4.
  - pc_src=1: npc = zero ? pc4 + (sext(instr[15:0])<<2) : pc4.
  - pc_src=2: npc={pc4[31:28], instr[25:0], 2'b00}.
  - pc_src=3: npc=rs_data.
- pc8=pc+8 at all times, combinational from pc.
- The misalignment check applies to every npc. Only pc_src=3 can actually produce a misaligned value.

## Timing
- Reset values:
  - pc=RESET_PC, state=FETCH, instr=0, retired=0, fetch_err=0.
  - instr_valid=0, imem_req=1 from the first cycle after reset.
- Reset has priority over every other event. Reset during FETCH drops any pending request and restarts at RESET_PC. An ack in the reset cycle is discarded.
- Fetch latency: an ack in the same cycle as req gives instr_valid=1 on the next cycle. A minimum fetch therefore takes 1 cycle in FETCH and 1 in HOLD.
- Commit in HOLD:
  - The new pc and the FETCH state appear on the next cycle; instr_valid drops in that same cycle.
  - pc_src, zero and rs_data are sampled in the commit cycle only.
- Back-to-back commits are impossible, because commit is only honoured in HOLD.
- imem_ack while imem_req=0 is ignored.
- npc at 32'hFFFF_FFFC with pc_src=0 wraps to 0. This is legal and aligned.

## Structure
- Shared package mips_pkg:
  - PcSrc encodings PC_SEQ=0, PC_BEQ=1, PC_J=2, PC_JR=3, shared with the controller.
  - Fetch state enum.
  - Default RESET_PC constant.
- One combinational sub-module, npc: inputs pc, instr, pc_src, zero, rs_data; outputs npc and pc8.
- ifu instantiates npc and contains the FSM, the pc/instr registers and the retired counter.

## Test plan
- Reset then ack in first cycle with rdata=32'h3421_0005 -> next cycle instr_valid=1, instr=32'h3421_0005, pc=32'h3000, pc8=32'h3008.
- HOLD at pc=32'h3000, commit, pc_src=0 -> pc=32'h3004, FETCH, imem_addr=32'h3004, retired=1.
- instr=32'h1000_FFFF at pc=32'h3010, pc_src=1:
  - zero=1 -> pc=32'h3010.
  - zero=0 -> pc=32'h3014.
- jal instr=32'h0C00_0C10 at pc=32'h3020, pc_src=2 -> pc=32'h0000_3040. Before the commit, pc8=32'h3028.
- pc_src=3, rs_data=32'h0000_3102, commit -> ERR, fetch_err=1, instr_valid=0, imem_req=0, pc stays. A following reset clears fetch_err and restores pc=32'h3000.
- Ack delayed 5 cycles -> imem_req and imem_addr stay stable throughout. A commit pulse during FETCH leaves pc and retired unchanged.
